// File: rtl/pdatapath_controller.sv
// Multi-cycle fetch/decode/execute sequencer for the 16-bit six-instruction datapath.
// Every datapath control line is a Moore function of the FSM state and the latched IR.
module pdatapath_controller #(
  parameter int         PC_W    = 7,
  parameter logic [2:0] ALU_ADD = 3'd1,
  parameter logic [2:0] ALU_SUB = 3'd2
) (
  input  logic            Clock,
  input  logic            Reset,
  input  logic [15:0]     I_data,
  output logic [PC_W-1:0] I_addr,
  output logic            I_rd,
  output logic [7:0]      D_addr,
  output logic            D_wr,
  output logic            RF_s,
  output logic [3:0]      RF_W_addr,
  output logic            RF_W_en,
  output logic [3:0]      RF_Ra_addr,
  output logic [3:0]      RF_Rb_addr,
  output logic [2:0]      ALU_s0,
  output logic            Halted,
  output logic [PC_W-1:0] PC_out
);

  typedef enum logic [3:0] {
    S_INIT, S_FETCH, S_DECODE, S_LOAD_A, S_LOAD_B,
    S_STORE, S_ADD, S_SUB, S_NOOP, S_HALT
  } state_t;

  state_t          state, state_nxt;
  logic [PC_W-1:0] pc;
  // The opcode is consumed straight from I_data in DECODE, so only the operand fields are held.
  logic [11:0]     ir;
  logic            i_rd_raw, d_wr_raw, rf_w_en_raw;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= S_INIT;
      pc    <= '0;
      ir    <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        S_INIT: begin
          pc <= '0;
          ir <= '0;
        end
        S_DECODE: begin
          ir <= I_data[11:0];
          pc <= pc + {{(PC_W-1){1'b0}}, 1'b1};
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt   = state;
    i_rd_raw    = 1'b0;
    d_wr_raw    = 1'b0;
    rf_w_en_raw = 1'b0;
    RF_s        = 1'b0;
    D_addr      = '0;
    RF_W_addr   = '0;
    RF_Ra_addr  = '0;
    RF_Rb_addr  = '0;
    ALU_s0      = '0;
    case (state)
      S_INIT:  state_nxt = S_FETCH;
      S_FETCH: begin
        i_rd_raw  = 1'b1;
        state_nxt = S_DECODE;
      end
      S_DECODE: begin
        case (I_data[15:12])
          4'd1:    state_nxt = S_STORE;
          4'd2:    state_nxt = S_LOAD_A;
          4'd3:    state_nxt = S_ADD;
          4'd4:    state_nxt = S_SUB;
          4'd5:    state_nxt = S_HALT;
          default: state_nxt = S_NOOP;
        endcase
      end
      // RAM read has one cycle of latency, so the RF write lands one state later.
      S_LOAD_A: begin
        D_addr    = ir[7:0];
        state_nxt = S_LOAD_B;
      end
      S_LOAD_B: begin
        D_addr      = ir[7:0];
        RF_s        = 1'b1;
        RF_W_addr   = ir[11:8];
        rf_w_en_raw = 1'b1;
        state_nxt   = S_FETCH;
      end
      S_STORE: begin
        RF_Ra_addr = ir[11:8];
        D_addr     = ir[7:0];
        d_wr_raw   = 1'b1;
        state_nxt  = S_FETCH;
      end
      S_ADD, S_SUB: begin
        RF_Ra_addr  = ir[11:8];
        RF_Rb_addr  = ir[7:4];
        ALU_s0      = (state == S_ADD) ? ALU_ADD : ALU_SUB;
        RF_W_addr   = ir[3:0];
        rf_w_en_raw = 1'b1;
        state_nxt   = S_FETCH;
      end
      S_NOOP:  state_nxt = S_FETCH;
      S_HALT:  state_nxt = S_HALT;
      default: state_nxt = S_INIT;
    endcase
  end

  // Reset gates the enables combinationally so an interrupted instruction never commits.
  assign I_rd    = i_rd_raw    & ~Reset;
  assign D_wr    = d_wr_raw    & ~Reset;
  assign RF_W_en = rf_w_en_raw & ~Reset;
  assign Halted  = (state == S_HALT);
  assign I_addr  = pc;
  assign PC_out  = pc;

endmodule

// File: tb/tb_pdatapath_controller.sv
// Bench for pdatapath_controller: ROM/RAM/RF environment around the DUT, directed
// scenarios plus random programs checked against an instruction-level ISA model.
module tb_pdatapath_controller;

  typedef struct packed {
    logic        is_ram;
    logic [7:0]  addr;
    logic [15:0] data;
    logic [3:0]  sel;   // RAM write: source reg; RF write: {RF_s, ALU_s0}
  } wr_t;

  logic Clock = 1'b0;
  always #5 Clock = ~Clock;
  logic Reset = 1'b1;

  logic [15:0] I_data;
  logic [6:0]  I_addr, PC_out;
  logic        I_rd, D_wr, RF_s, RF_W_en, Halted;
  logic [7:0]  D_addr;
  logic [3:0]  RF_W_addr, RF_Ra_addr, RF_Rb_addr;
  logic [2:0]  ALU_s0;

  logic [15:0] I_data2 = 16'h0000;
  logic [1:0]  I_addr2, PC_out2;
  logic        I_rd2, D_wr2, RF_s2, RF_W_en2, Halted2;
  logic [7:0]  D_addr2;
  logic [3:0]  RF_W_addr2, RF_Ra_addr2, RF_Rb_addr2;
  logic [2:0]  ALU_s02;

  pdatapath_controller #(.PC_W(7)) dut (
    .Clock(Clock), .Reset(Reset), .I_data(I_data), .I_addr(I_addr), .I_rd(I_rd),
    .D_addr(D_addr), .D_wr(D_wr), .RF_s(RF_s), .RF_W_addr(RF_W_addr), .RF_W_en(RF_W_en),
    .RF_Ra_addr(RF_Ra_addr), .RF_Rb_addr(RF_Rb_addr), .ALU_s0(ALU_s0), .Halted(Halted),
    .PC_out(PC_out));

  pdatapath_controller #(.PC_W(2)) dut2 (
    .Clock(Clock), .Reset(Reset), .I_data(I_data2), .I_addr(I_addr2), .I_rd(I_rd2),
    .D_addr(D_addr2), .D_wr(D_wr2), .RF_s(RF_s2), .RF_W_addr(RF_W_addr2), .RF_W_en(RF_W_en2),
    .RF_Ra_addr(RF_Ra_addr2), .RF_Rb_addr(RF_Rb_addr2), .ALU_s0(ALU_s02), .Halted(Halted2),
    .PC_out(PC_out2));

  // Datapath environment: sync ROM, sync-read RAM, register file, ALU
  logic [15:0] rom [128];
  logic [15:0] ram [256];
  logic [15:0] rf  [16];
  logic [15:0] ram_q, alu_v;

  assign alu_v = (ALU_s0 == 3'd1) ? rf[RF_Ra_addr] + rf[RF_Rb_addr] :
                 (ALU_s0 == 3'd2) ? rf[RF_Ra_addr] - rf[RF_Rb_addr] : 16'h0000;

  always @(posedge Clock) begin
    logic [15:0] wd, sd;
    wd = RF_s ? ram_q : alu_v;
    sd = rf[RF_Ra_addr];
    if (I_rd) I_data <= rom[I_addr];
    ram_q <= ram[D_addr];
    if (D_wr) ram[D_addr] = sd;
    if (RF_W_en) rf[RF_W_addr] = wd;
  end

  // Monitor
  int  cyc = 0, rel_cyc = 0, both_hi = 0, halt_en = 0, w2_cnt = 0;
  int  fc_q[$], fa_q[$], f2_q[$];
  wr_t wr_q[$];

  always @(negedge Clock) begin
    cyc++;
    if (I_rd) begin fc_q.push_back(cyc); fa_q.push_back(int'(I_addr)); end
    if (RF_W_en) wr_q.push_back('{1'b0, {4'h0, RF_W_addr}, RF_s ? ram_q : alu_v, {RF_s, ALU_s0}});
    if (D_wr) wr_q.push_back('{1'b1, D_addr, rf[RF_Ra_addr], RF_Ra_addr});
    if (D_wr && RF_W_en) both_hi++;
    if (Halted && (I_rd || D_wr || RF_W_en)) halt_en++;
    if (I_rd2) f2_q.push_back(int'(I_addr2));
    if (D_wr2 || RF_W_en2) w2_cnt++;
  end

  int ncmp = 0, nerr = 0;

  // ISA-level reference model
  logic [15:0] mrom [128];
  logic [15:0] mram [256];
  logic [15:0] mrf  [16];
  int  efc_q[$], efa_q[$];
  wr_t ewr_q[$];
  int  exp_pc;
  bit  exp_halt;

  task automatic model_run();
    int pc, c;
    logic [15:0] ir, v;
    pc = 0; c = 0; exp_halt = 0;
    efc_q.delete(); efa_q.delete(); ewr_q.delete();
    for (int n = 0; n < 1000 && !exp_halt; n++) begin
      efc_q.push_back(c); efa_q.push_back(pc);
      ir = mrom[pc];
      pc = (pc + 1) % 128;
      case (ir[15:12])
        4'd1: begin v = mrf[ir[11:8]]; mram[ir[7:0]] = v;
                ewr_q.push_back('{1'b1, ir[7:0], v, ir[11:8]}); c += 3; end
        4'd2: begin v = mram[ir[7:0]]; mrf[ir[11:8]] = v;
                ewr_q.push_back('{1'b0, {4'h0, ir[11:8]}, v, 4'b1000}); c += 4; end
        4'd3: begin v = mrf[ir[11:8]] + mrf[ir[7:4]]; mrf[ir[3:0]] = v;
                ewr_q.push_back('{1'b0, {4'h0, ir[3:0]}, v, 4'b0001}); c += 3; end
        4'd4: begin v = mrf[ir[11:8]] - mrf[ir[7:4]]; mrf[ir[3:0]] = v;
                ewr_q.push_back('{1'b0, {4'h0, ir[3:0]}, v, 4'b0010}); c += 3; end
        4'd5: exp_halt = 1;
        default: c += 3;
      endcase
    end
    exp_pc = pc;
  endtask

  task automatic hold_reset();
    Reset = 1'b1;
    @(posedge Clock); #2;
    for (int i = 0; i < 128; i++) rom[i] = 16'h0000;
    for (int i = 0; i < 256; i++) ram[i] = 16'h0000;
    for (int i = 0; i < 16; i++)  rf[i]  = 16'h0000;
  endtask

  task automatic release_rst();
    fc_q.delete(); fa_q.delete(); wr_q.delete(); f2_q.delete();
    both_hi = 0; halt_en = 0; w2_cnt = 0;
    rel_cyc = cyc;
    Reset = 1'b0;
  endtask

  task automatic run_prog(input int budget, output bit ok);
    int n;
    for (int i = 0; i < 128; i++) mrom[i] = rom[i];
    for (int i = 0; i < 256; i++) mram[i] = ram[i];
    for (int i = 0; i < 16; i++)  mrf[i]  = rf[i];
    model_run();
    release_rst();
    n = 0;
    while (Halted !== 1'b1 && n < budget) begin @(negedge Clock); n++; end
    ok = (Halted === 1'b1);
    repeat (20) @(negedge Clock);
    #1;
  endtask

  task automatic test_reset();
    #2;
    ncmp++; if ({I_rd, D_wr, RF_W_en} !== 3'b000) begin nerr++; $display("FAIL reset_enables_comb: got %b want 000", {I_rd, D_wr, RF_W_en}); end
    @(posedge Clock); #2;
    ncmp++; if ({I_addr, I_rd, D_addr, D_wr, RF_s, RF_W_addr, RF_W_en, RF_Ra_addr, RF_Rb_addr, ALU_s0, Halted, PC_out} !== '0) begin
      nerr++; $display("FAIL reset_outputs: got I_rd=%b D_wr=%b RF_W_en=%b Halted=%b PC_out=%0d want all 0", I_rd, D_wr, RF_W_en, Halted, PC_out); end
  endtask

  task automatic test_load();
    bit ok;
    hold_reset();
    rom[0] = 16'h2110; rom[1] = 16'h5000; ram[8'h10] = 16'h0007;
    run_prog(100, ok);
    ncmp++; if (!ok) begin nerr++; $display("FAIL load_halt_timeout: got Halted=%b want 1", Halted); end
    ncmp++; if (rf[1] !== 16'h0007) begin nerr++; $display("FAIL load_rf1: got %h want 0007", rf[1]); end
    ncmp++; if (fc_q.size() !== 2) begin nerr++; $display("FAIL load_fetch_count: got %0d want 2", fc_q.size()); end
    else begin
      ncmp++; if (fc_q[0] - rel_cyc !== 2) begin nerr++; $display("FAIL load_first_fetch: got %0d want 2", fc_q[0] - rel_cyc); end
      ncmp++; if (fc_q[1] - fc_q[0] !== 4) begin nerr++; $display("FAIL load_cpi: got %0d want 4", fc_q[1] - fc_q[0]); end
      ncmp++; if (fa_q[1] !== 1) begin nerr++; $display("FAIL load_fetch_addr1: got %0d want 1", fa_q[1]); end
    end
    ncmp++; if (wr_q.size() !== 1) begin nerr++; $display("FAIL load_write_count: got %0d want 1", wr_q.size()); end
    else begin
      ncmp++; if (wr_q[0] !== wr_t'({1'b0, 8'h01, 16'h0007, 4'b1000})) begin nerr++; $display("FAIL load_write: got %h want %h", wr_q[0], wr_t'({1'b0, 8'h01, 16'h0007, 4'b1000})); end
    end
  endtask

  task automatic test_alu();
    bit ok;
    wr_t exp_w[3];
    hold_reset();
    rf[1] = 16'h0007; rf[2] = 16'h0003;
    rom[0] = 16'h3123; rom[1] = 16'h4124; rom[2] = 16'h4210; rom[3] = 16'h5000;
    exp_w[0] = '{1'b0, 8'h03, 16'h000A, 4'b0001};
    exp_w[1] = '{1'b0, 8'h04, 16'h0004, 4'b0010};
    exp_w[2] = '{1'b0, 8'h00, 16'hFFFC, 4'b0010};
    run_prog(100, ok);
    ncmp++; if (!ok) begin nerr++; $display("FAIL alu_halt_timeout: got Halted=%b want 1", Halted); end
    ncmp++; if (rf[3] !== 16'h000A) begin nerr++; $display("FAIL alu_add_r3: got %h want 000a", rf[3]); end
    ncmp++; if (rf[4] !== 16'h0004) begin nerr++; $display("FAIL alu_sub_r4: got %h want 0004", rf[4]); end
    ncmp++; if (rf[0] !== 16'hFFFC) begin nerr++; $display("FAIL alu_sub_wrap_r0: got %h want fffc", rf[0]); end
    ncmp++; if (wr_q.size() !== 3) begin nerr++; $display("FAIL alu_write_count: got %0d want 3", wr_q.size()); end
    else for (int i = 0; i < 3; i++) begin
      ncmp++; if (wr_q[i] !== exp_w[i]) begin nerr++; $display("FAIL alu_write%0d: got %h want %h", i, wr_q[i], exp_w[i]); end
    end
    ncmp++; if (fc_q.size() !== 4) begin nerr++; $display("FAIL alu_fetch_count: got %0d want 4", fc_q.size()); end
    else begin
      ncmp++; if (fc_q[3] - fc_q[0] !== 9) begin nerr++; $display("FAIL alu_cpi: got %0d want 9", fc_q[3] - fc_q[0]); end
    end
  endtask

  task automatic test_store_noop_halt();
    bit ok;
    hold_reset();
    rf[3] = 16'h000A;
    rom[0] = 16'h1355; rom[4] = 16'hF000; rom[5] = 16'h5000;
    run_prog(100, ok);
    ncmp++; if (!ok) begin nerr++; $display("FAIL store_halt_timeout: got Halted=%b want 1", Halted); end
    ncmp++; if (ram[8'h55] !== 16'h000A) begin nerr++; $display("FAIL store_ram55: got %h want 000a", ram[8'h55]); end
    ncmp++; if (wr_q.size() !== 1) begin nerr++; $display("FAIL store_write_count: got %0d want 1", wr_q.size()); end
    else begin
      ncmp++; if (wr_q[0] !== wr_t'({1'b1, 8'h55, 16'h000A, 4'h3})) begin nerr++; $display("FAIL store_write: got %h want %h", wr_q[0], wr_t'({1'b1, 8'h55, 16'h000A, 4'h3})); end
    end
    ncmp++; if (fc_q.size() !== 6) begin nerr++; $display("FAIL halt_fetch_count: got %0d want 6", fc_q.size()); end
    else begin
      ncmp++; if (fc_q[5] - fc_q[4] !== 3) begin nerr++; $display("FAIL noop_f_cpi: got %0d want 3", fc_q[5] - fc_q[4]); end
    end
    ncmp++; if (PC_out !== 7'd6) begin nerr++; $display("FAIL halt_pc: got %0d want 6", PC_out); end
    ncmp++; if (Halted !== 1'b1) begin nerr++; $display("FAIL halt_sticky: got %b want 1", Halted); end
    ncmp++; if (halt_en !== 0) begin nerr++; $display("FAIL halt_enables: got %0d want 0", halt_en); end
  endtask

  task automatic test_reset_mid();
    int n;
    // interrupt a STORE
    hold_reset();
    rom[0] = 16'h1355; rf[3] = 16'h000A; ram[8'h55] = 16'h1234;
    release_rst();
    n = 0;
    do begin @(negedge Clock); n++; end while (D_wr !== 1'b1 && n < 10);
    ncmp++; if (D_wr !== 1'b1) begin nerr++; $display("FAIL rmid_store_reach: got D_wr=%b want 1", D_wr); end
    Reset = 1'b1; #1;
    ncmp++; if ({D_wr, RF_W_en} !== 2'b00) begin nerr++; $display("FAIL rmid_store_gate: got %b want 00", {D_wr, RF_W_en}); end
    @(posedge Clock); #2;
    ncmp++; if (ram[8'h55] !== 16'h1234) begin nerr++; $display("FAIL rmid_store_ram: got %h want 1234", ram[8'h55]); end
    release_rst();
    @(negedge Clock);
    ncmp++; if (I_rd !== 1'b0) begin nerr++; $display("FAIL rmid_init_cycle: got I_rd=%b want 0", I_rd); end
    @(negedge Clock);
    ncmp++; if ({I_rd, I_addr} !== {1'b1, 7'd0}) begin nerr++; $display("FAIL rmid_refetch: got I_rd=%b I_addr=%0d want 1/0", I_rd, I_addr); end
    // interrupt a LOAD in its write state
    hold_reset();
    rom[0] = 16'h2110; ram[8'h10] = 16'h0007; rf[1] = 16'h5555;
    release_rst();
    n = 0;
    do begin @(negedge Clock); n++; end while (RF_W_en !== 1'b1 && n < 10);
    ncmp++; if (RF_W_en !== 1'b1) begin nerr++; $display("FAIL rmid_load_reach: got RF_W_en=%b want 1", RF_W_en); end
    Reset = 1'b1; #1;
    ncmp++; if ({D_wr, RF_W_en} !== 2'b00) begin nerr++; $display("FAIL rmid_load_gate: got %b want 00", {D_wr, RF_W_en}); end
    @(posedge Clock); #2;
    ncmp++; if (rf[1] !== 16'h5555) begin nerr++; $display("FAIL rmid_load_rf: got %h want 5555", rf[1]); end
    // leave HALT through reset
    hold_reset();
    rom[1] = 16'h5000;
    release_rst();
    n = 0;
    while (Halted !== 1'b1 && n < 20) begin @(negedge Clock); n++; end
    ncmp++; if ({Halted, PC_out} !== {1'b1, 7'd2}) begin nerr++; $display("FAIL rhalt_pre: got Halted=%b PC=%0d want 1/2", Halted, PC_out); end
    Reset = 1'b1;
    @(posedge Clock); #2;
    ncmp++; if ({Halted, PC_out, I_rd} !== 9'd0) begin nerr++; $display("FAIL rhalt_post: got Halted=%b PC=%0d I_rd=%b want 0", Halted, PC_out, I_rd); end
  endtask

  task automatic test_wrap();
    hold_reset();
    release_rst();
    repeat (25) @(negedge Clock);
    ncmp++; if (f2_q.size() < 6) begin nerr++; $display("FAIL wrap_fetch_count: got %0d want >=6", f2_q.size()); end
    else for (int k = 0; k < 6; k++) begin
      ncmp++; if (f2_q[k] !== k % 4) begin nerr++; $display("FAIL wrap_addr%0d: got %0d want %0d", k, f2_q[k], k % 4); end
    end
    ncmp++; if (w2_cnt !== 0) begin nerr++; $display("FAIL wrap_writes: got %0d want 0", w2_cnt); end
  endtask

  task automatic test_random();
    bit ok;
    logic [3:0] op;
    for (int r = 0; r < 4; r++) begin
      hold_reset();
      for (int i = 0; i < 256; i++) ram[i] = 16'($urandom);
      for (int i = 0; i < 16; i++)  rf[i]  = 16'($urandom);
      for (int i = 0; i < 30; i++) begin
        op = 4'($urandom_range(0, 15));
        if (op == 4'd5 && $urandom_range(0, 3) != 0) op = 4'd3;
        rom[i] = {op, 12'($urandom)};
      end
      rom[30] = 16'h5000;
      run_prog(400, ok);
      ncmp++; if (!ok) begin nerr++; $display("FAIL rnd%0d_halt_timeout: got Halted=%b want 1", r, Halted); end
      ncmp++; if (fc_q.size() !== efa_q.size()) begin nerr++; $display("FAIL rnd%0d_fetch_count: got %0d want %0d", r, fc_q.size(), efa_q.size()); end
      else begin
        ncmp++; if (fc_q[0] - rel_cyc !== 2) begin nerr++; $display("FAIL rnd%0d_first_fetch: got %0d want 2", r, fc_q[0] - rel_cyc); end
        for (int i = 0; i < fc_q.size(); i++) begin
          ncmp++; if (fa_q[i] !== efa_q[i] || fc_q[i] - fc_q[0] !== efc_q[i]) begin nerr++;
            $display("FAIL rnd%0d_fetch%0d: got addr %0d at +%0d want addr %0d at +%0d", r, i, fa_q[i], fc_q[i] - fc_q[0], efa_q[i], efc_q[i]); end
        end
      end
      ncmp++; if (wr_q.size() !== ewr_q.size()) begin nerr++; $display("FAIL rnd%0d_write_count: got %0d want %0d", r, wr_q.size(), ewr_q.size()); end
      else for (int i = 0; i < wr_q.size(); i++) begin
        ncmp++; if (wr_q[i] !== ewr_q[i]) begin nerr++; $display("FAIL rnd%0d_write%0d: got %h want %h", r, i, wr_q[i], ewr_q[i]); end
      end
      for (int i = 0; i < 16; i++) begin
        ncmp++; if (rf[i] !== mrf[i]) begin nerr++; $display("FAIL rnd%0d_rf%0d: got %h want %h", r, i, rf[i], mrf[i]); end
      end
      for (int i = 0; i < 256; i++) begin
        ncmp++; if (ram[i] !== mram[i]) begin nerr++; $display("FAIL rnd%0d_ram%0h: got %h want %h", r, i, ram[i], mram[i]); end
      end
      ncmp++; if (PC_out !== 7'(exp_pc)) begin nerr++; $display("FAIL rnd%0d_pc: got %0d want %0d", r, PC_out, exp_pc); end
      ncmp++; if (both_hi !== 0 || halt_en !== 0) begin nerr++; $display("FAIL rnd%0d_exclusive: got both=%0d halt_en=%0d want 0/0", r, both_hi, halt_en); end
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_alu();
    test_store_noop_halt();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
